// File: rtl/fsm_tx.sv
// ---------------------------------------------------------------------------
// fsm_tx -- framed serial transmitter
//
// Sends one payload word per frame on an idle-high serial line:
//   START (0), DATA_W payload bits LSB first, optional even-parity bit,
//   STOP (1). Every bit lasts DIV clock cycles.
//
// Optional feature macro: FSM_TX_PARITY_EN
//   defined   -> a PARITY bit (XOR of the latched payload) sits between the
//                last DATA bit and STOP; frame = (DATA_W+3)*DIV cycles.
//   undefined -> no parity state or logic; frame = (DATA_W+2)*DIV cycles.
//
// Parameters
//   DATA_W     payload bits per frame (1..16)
//   DIV        clock cycles per serial bit (1..255)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   payload offered
//   in_data    payload word
//   in_ready   block can accept a payload (high only in IDLE)
//   out        registered serial line, idle-high
//   busy       frame in progress (state != IDLE)
//   done       one-cycle pulse in the first IDLE cycle after STOP
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: a payload transfers on a rising clk edge where
// in_valid && in_ready are both 1. in_ready does not depend on in_valid.
// in_valid offered while in_ready is 0 is ignored, and in_data is sampled
// only on the transfer edge.
// ---------------------------------------------------------------------------
module fsm_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FSM_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_DIV = 8'(DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  state_t              r_state;
  logic [7:0]          r_div;
  logic [4:0]          r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_out;
  logic                r_done;

  state_t              w_state_nxt;
  logic [7:0]          w_div_nxt;
  logic [4:0]          w_bit_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_out_nxt;
  logic                w_done_nxt;
  logic                w_bit_end;
  logic                w_accept;

`ifdef FSM_TX_PARITY_EN
  logic                r_par;
  logic                w_par_nxt;
`endif

  assign w_bit_end = (r_div == LAST_DIV);
  assign w_accept  = in_valid && (r_state == IDLE);

  // Next-state, counters, shift register and the next value of the
  // registered serial line.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
`ifdef FSM_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_shift_nxt = in_data;
          w_div_nxt   = 8'd0;
          w_bit_nxt   = 5'd0;
`ifdef FSM_TX_PARITY_EN
          w_par_nxt   = ^in_data;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_div_nxt   = 8'd0;
        end else begin
          w_div_nxt   = r_div + 8'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_div_nxt   = 8'd0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_bit_nxt   = 5'd0;
`ifdef FSM_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + 5'd1;
          end
        end else begin
          w_div_nxt   = r_div + 8'd1;
        end
      end
`ifdef FSM_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_div_nxt   = 8'd0;
        end else begin
          w_div_nxt   = r_div + 8'd1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_div_nxt   = 8'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_nxt   = r_div + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_div_nxt   = 8'd0;
        w_bit_nxt   = 5'd0;
      end
    endcase

    // The line value is chosen from the state being entered so that the
    // flop shows the right bit in the same cycle as the new state.
    case (w_state_nxt)
      START:   w_out_nxt = 1'b0;
      DATA:    w_out_nxt = w_shift_nxt[0];
`ifdef FSM_TX_PARITY_EN
      PARITY:  w_out_nxt = w_par_nxt;
`endif
      default: w_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_bit   <= 5'd0;
      r_shift <= '0;
      r_out   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef FSM_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out       = r_out;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fsm_tx.sv
// ---------------------------------------------------------------------------
// tb_fsm_tx -- directed bench for fsm_tx
//
// Two instances: u_dut (DATA_W=8, DIV=4) and u_dut1 (DATA_W=8, DIV=1).
// Inputs are driven on the falling edge, outputs sampled on the falling
// edge. Expected line values per cycle are queued in exp_q and popped one
// per cycle while the frame is in flight.
// ---------------------------------------------------------------------------
module tb_fsm_tx;

`ifdef FSM_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int DIV0 = 4;

  logic       clk;
  logic       rst;
  logic       in_valid, in_valid1;
  logic [7:0] in_data, in_data1;
  logic       in_ready, in_ready1;
  logic       out, out1;
  logic       busy, busy1;
  logic       done, done1;
  logic [2:0] dbg_state, dbg_state1;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];

  fsm_tx #(.DATA_W(8), .DIV(DIV0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  fsm_tx #(.DATA_W(8), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out(out1), .busy(busy1), .done(done1),
    .dbg_state(dbg_state1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line sequence for one DIV0 frame carrying data.
  task automatic build_exp(input logic [7:0] data);
    exp_q.delete();
    repeat (DIV0) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (DIV0) exp_q.push_back(data[b]);
    end
    if (PAR_BITS == 1) begin
      repeat (DIV0) exp_q.push_back(^data);
    end
    repeat (DIV0) exp_q.push_back(1'b1);
  endtask

  // Precondition: at a falling edge, u_dut idle, in_valid=1, in_data=data.
  // Returns at the falling edge of the done cycle. After the accept edge
  // the inputs become hold_v/nxt; pulse_at >= 0 injects a one-cycle
  // in_valid=1 with 0x3C at that frame cycle.
  task automatic run_frame(input logic [7:0] data, input logic hold_v,
                           input logic [7:0] nxt, input int pulse_at);
    int len;
    logic [0:0] e;
    build_exp(data);
    len = exp_q.size();
    chk("ready_before_accept", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = hold_v;
    in_data  = nxt;
    chk("state_start", {5'd0, dbg_state}, 8'd1);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (i == pulse_at) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end else if (i == pulse_at + 1) begin
        in_valid = hold_v;
        in_data  = nxt;
      end
      e = exp_q.pop_front();
      chk("frame_out", {7'd0, out}, {7'd0, e});
      chk("frame_busy", {7'd0, busy}, 8'd1);
      chk("frame_done", {7'd0, done}, 8'd0);
      chk("frame_ready", {7'd0, in_ready}, 8'd0);
    end
    @(negedge clk);
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("done_out_idle", {7'd0, out}, 8'd1);
    chk("done_busy", {7'd0, busy}, 8'd0);
    chk("done_ready", {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_valid1 = 1'b0;
    in_data1  = 8'h00;

    // reset state
    #3;
    chk("rst_out", {7'd0, out}, 8'd1);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_state", {5'd0, dbg_state}, 8'd0);
    chk("rst_out1", {7'd0, out1}, 8'd1);
    chk("rst_busy1", {7'd0, busy1}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 0xA5 (even parity 0), accepted on the first edge after reset
    in_valid = 1'b1;
    in_data  = 8'hA5;
    run_frame(8'hA5, 1'b0, 8'hFF, -1);
    @(negedge clk);
    chk("a5_done_once", {7'd0, done}, 8'd0);
    chk("a5_stays_idle", {7'd0, busy}, 8'd0);

    // 0x07 (even parity 1)
    in_valid = 1'b1;
    in_data  = 8'h07;
    run_frame(8'h07, 1'b0, 8'h00, -1);
    @(negedge clk);

    // back-to-back 0x00 then 0xFF, in_valid held high throughout
    in_valid = 1'b1;
    in_data  = 8'h00;
    run_frame(8'h00, 1'b1, 8'hFF, -1);
    run_frame(8'hFF, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk("b2b_no_third", {7'd0, busy}, 8'd0);

    // in_valid pulse with 0x3C while busy is ignored
    in_valid = 1'b1;
    in_data  = 8'h5A;
    run_frame(8'h5A, 1'b0, 8'h00, 10);
    repeat (3) begin
      @(negedge clk);
      chk("pulse_no_extra_busy", {7'd0, busy}, 8'd0);
      chk("pulse_no_extra_out", {7'd0, out}, 8'd1);
    end

    // reset during DATA bit 3 of 0x96 (bit 3 = 0)
    in_valid = 1'b1;
    in_data  = 8'h96;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4 * DIV0) @(negedge clk);
    chk("mid_state_data", {5'd0, dbg_state}, 8'd2);
    chk("mid_bit3", {7'd0, out}, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", {7'd0, out}, 8'd1);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_ready", {7'd0, in_ready}, 8'd1);
    chk("mid_rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    chk("mid_rst_hold_done", {7'd0, done}, 8'd0);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    run_frame(8'h3C, 1'b0, 8'h00, -1);
    @(negedge clk);

    // DIV=1 instance, 0x81
    exp_q.delete();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if (PAR_BITS == 1) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    in_valid1 = 1'b1;
    in_data1  = 8'h81;
    chk("div1_ready", {7'd0, in_ready1}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = 8'h00;
    for (int i = 0; i < 10 + PAR_BITS; i++) begin
      if (i > 0) @(negedge clk);
      chk("div1_out", {7'd0, out1}, {7'd0, exp_q.pop_front()});
      chk("div1_busy", {7'd0, busy1}, 8'd1);
    end
    @(negedge clk);
    chk("div1_end_busy", {7'd0, busy1}, 8'd0);
    chk("div1_done", {7'd0, done1}, 8'd1);
    chk("div1_idle_out", {7'd0, out1}, 8'd1);
    @(negedge clk);
    chk("div1_done_once", {7'd0, done1}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_tx.md
FSM_TX -- requirements
Module: fsm_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  payload offered.
REQ-006 The block SHALL have port in_data  input  DATA_W  payload word.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a payload.
REQ-008 The block SHALL have port out  output  1  serial line, idle-high.
REQ-009 The block SHALL have port busy  output  1  frame in progress.
REQ-010 The block SHALL have port done  output  1  single-cycle frame-complete pulse.

Function
REQ-011 The block SHALL implement a registered state machine with states IDLE, START, DATA, PARITY, STOP, using a 3-bit enumerated type, a combinational next-state block and a sequential state register.
REQ-012 The block SHALL drive in_ready=1 only in IDLE and SHALL accept a payload on a cycle where in_valid && in_ready; the accept edge latches in_data into a shift register and moves IDLE->START.
REQ-013 The block SHALL hold every non-IDLE state for exactly DIV cycles per bit, using a divider counter 0..DIV-1 that clears on every state or bit change.
REQ-014 The block SHALL drive out as follows: IDLE=1, START=0, DATA=current shift-register LSB (LSB first), PARITY=even parity (XOR of all DATA_W latched bits), STOP=1; out SHALL be registered, with no combinational path from inputs.
REQ-015 The block SHALL remain in DATA for DATA_W bits, counted by a bit counter 0..DATA_W-1, shifting right once per completed bit; after the last bit it SHALL move to PARITY when parity is compiled in, else to STOP.
REQ-016 The block SHALL move STOP->IDLE after DIV cycles, and done SHALL be 1 for exactly the first IDLE cycle after STOP.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 Frame length from the accept edge to the STOP->IDLE edge SHALL be (DATA_W+2)*DIV cycles, or (DATA_W+3)*DIV with parity.
REQ-019 in_valid while busy SHALL be ignored; in_data changes after accept SHALL NOT affect out.
REQ-020 Back-to-back frames SHALL be possible: a payload accepted in the done cycle starts START on the next cycle, giving exactly one idle-high cycle between frames.
REQ-021 With DIV=1, each bit SHALL last one cycle, with no divider wrap errors.

Reset
REQ-022 rst SHALL asynchronously force state=IDLE, out=1, in_ready=1, busy=0, done=0, and clear the divider counter, bit counter and shift register, including mid-frame.
REQ-023 On the first rising clk edge after rst deasserts, the block SHALL be able to accept a payload.

Configuration
REQ-024 Macro FSM_TX_PARITY_EN defined: the PARITY state SHALL exist and be inserted between DATA and STOP, carrying even parity for DIV cycles.
REQ-025 Macro FSM_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, DATA SHALL go directly to STOP, and the frame SHALL be (DATA_W+2)*DIV cycles.

Verification
REQ-026 DIV=4, DATA_W=8, parity off, send 0xA5 -> out = 0 (4 cyc), bits 1,0,1,0,0,1,0,1 (4 cyc each), 1 (4 cyc); done pulses at cycle 40 after accept.
REQ-027 Parity on, send 0xA5 -> PARITY bit 0 for 4 cycles; send 0x07 -> PARITY bit 1; frame = 44 cycles.
REQ-028 Back-to-back 0x00 then 0xFF with in_valid held high -> exactly one out=1 cycle between STOP of frame 1 and START of frame 2; the second accept occurs in the done cycle.
REQ-029 Assert rst during the DATA bit 3 of a frame -> out=1, busy=0, in_ready=1 immediately; no done pulse; the next frame transmits correctly.
REQ-030 in_valid pulsed with 0x3C while busy -> ignored; the in-flight frame is unchanged and no extra frame follows.
REQ-031 DIV=1, send 0x81 -> out 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; busy for 10 cycles.
